vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port 32 KB video RAM (15-bit address, 8-bit data) between the ULA video fetch engine and CPU-side memory accesses to the screen pages. Sits between the ULA's `vram_addr`/`vram_dout` path and the physical VRAM. Sequences one access at a time through a small state machine, gives the ULA fixed priority, and returns read data with a one-cycle acknowledge pulse. An optional starvation guard bounds CPU wait time.

## Interface
Parameters:
- `READ_LAT`, 1: clk_sys cycles from issue to valid `mem_dout` (1..3).
- `STARVE_LIMIT`, 4: consecutive ULA grants while the CPU is pending before the CPU is forced in (guard builds only).

Ports:
- `clk_sys` in 1: master clock; all logic is on its rising edge.
- `nRESET` in 1: asynchronous, active-low reset.
- `ula_req` in 1: ULA access request (read only).
- `ula_addr` in 15: ULA address.
- `ula_ack` out 1: one-cycle pulse; `ula_data` is valid in the same cycle.
- `ula_data` out 8: ULA read data.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 15: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: CPU read data; valid while `cpu_ack` is high and held until the next CPU read.
- `mem_addr` out 15, `mem_wdata` out 8, `mem_we` out 1, `mem_dout` in 8: VRAM port.
- `cpu_pending` out 1: CPU request is waiting or in flight; feeds contention and wait logic.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE** samples the requests:
  - `ula_req` wins over `cpu_req` when both are set.
  - On a grant, the owner, address, write data and we are latched. Next state is ISSUE.
- **ISSUE** drives the latched `mem_addr` for exactly 1 cycle.
  - `mem_we`=1 only for a CPU write.
  - A write goes to DONE.
  - A read goes to WAIT, or directly to DONE when `READ_LAT`=1.
- **WAIT** counts `READ_LAT`-1 further cycles.
- **DONE**:
  - Captures `mem_dout` into `ula_data` or `cpu_rdata`.
  - Pulses the owner's ack for 1 cycle.
  - Returns to IDLE.
- A requester holds req, addr and data stable until its ack. Req still high in the cycle after ack counts as a new request.
- `mem_addr` and `mem_wdata` hold their last value outside ISSUE. `mem_we` is 0 outside ISSUE.
- A drop of req before ack is a protocol violation: the access completes anyway and the ack is still issued.
- `cpu_pending`:
  - Set on the cycle when IDLE sees `cpu_req` but does not grant the CPU, or when the CPU is the current owner.
  - Cleared in the cycle after `cpu_ack`.
- Reset (asynchronous, any state):
  - Returns to IDLE and aborts any in-flight access with no ack.
  - All outputs go to 0, including `mem_addr` and both data registers.
  - The starvation counter goes to 0.

## Timing
- Grant decision in cycle T (IDLE), mem issue in T+1, ack in T+1+`READ_LAT` for reads and T+2 for writes.
- Back-to-back: the next IDLE is the cycle after ack. Maximum throughput is one access per `READ_LAT`+2 cycles for reads and per 3 cycles for writes.
- ULA worst-case latency from `ula_req` to `ula_ack` is one in-progress CPU access plus its own access: at most 2·(`READ_LAT`+2) cycles.
- Without the guard, CPU latency is unbounded while `ula_req` stays high.

## Configuration
- Macro `VRAM_ARB_STARVE_EN`.
- When defined:
  - A saturating counter, width `$clog2(STARVE_LIMIT+1)`, increments on each ULA grant made while `cpu_req` is high.
  - When the count equals `STARVE_LIMIT`, IDLE grants the CPU even if `ula_req` is high.
  - The counter clears on every CPU grant.
  - CPU latency is then bounded by (`STARVE_LIMIT`+1)·(`READ_LAT`+2)+1 cycles.
- When undefined: strict ULA priority, no counter logic.

## Structure
- Shared package `vram_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the owner enum (OWN_ULA, OWN_CPU);
  - the address width constant (15) and data width constant (8).
- Sub-module `vram_arb_starve` is the counter and force-grant logic. It is instantiated only under `VRAM_ARB_STARVE_EN`.

## Test plan
1. **Single reads.** `READ_LAT`=1, mem preloaded with addr[7:0]. ULA read 0x1800, then CPU read 0x1A5A. Required: `ula_data`=0x00 with `ula_ack` at T+2; `cpu_rdata`=0x5A with `cpu_ack` at T+2.
2. **Collision.** `ula_req` and `cpu_req` (write 0x3C to 0x0100) raised in the same cycle. Required: ULA is served first; `cpu_pending`=1 throughout; CPU write `mem_we` pulses exactly once, at the ULA ack cycle +2; read-back of 0x0100 returns 0x3C.
3. **Latency.** `READ_LAT`=3, CPU read. Required: `cpu_ack` exactly 4 cycles after grant; `mem_we` stays 0.
4. **Starvation guard.** Guard built, `STARVE_LIMIT`=4, `ula_req` held high, CPU read pending. Required: the 5th grant goes to the CPU; the counter returns to 0; ULA resumes. Guard not built: no CPU ack in 200 cycles.
5. **Reset mid-access.** `nRESET` asserted during WAIT of a CPU read. Required: immediately all outputs are 0 and no ack follows. After release, a fresh ULA read completes normally.
6. **Back-to-back.** `cpu_req` held high for 3 consecutive writes. Required: acks spaced exactly 3 cycles apart and 3 distinct `mem_we` pulses.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and widths for the VRAM arbiter slice.
package vram_arb_pkg;

  localparam int unsigned AddrWidth = 15;
  localparam int unsigned DataWidth = 8;

  // Access sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  // Who owns the access currently in flight
  typedef enum logic {
    OwnUla,
    OwnCpu
  } arb_owner_e;

endpackage

// File: rtl/vram_arb_starve.sv
// Starvation guard: counts ULA grants made while the CPU waits and forces a
// CPU grant once the count reaches STARVE_LIMIT. Used only when the top is
// built with VRAM_ARB_STARVE_EN.
module vram_arb_starve
  import vram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_sys,
  input  logic nRESET,
  input  logic ula_grant,
  input  logic cpu_grant,
  input  logic cpu_req,
  output logic force_cpu
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Saturating count of ULA grants that bypassed a waiting CPU
  always_comb begin
    cnt_d = cnt_q;
    if (cpu_grant) begin
      cnt_d = '0;
    end else if (ula_grant && cpu_req && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_cpu = (cnt_q == Limit);

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single-port 32 KB video RAM between the ULA fetch
// engine and CPU accesses. One access at a time, ULA has fixed priority.
// Optional starvation guard enabled by defining VRAM_ARB_STARVE_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_sys,
  input  logic                 nRESET,
  // ULA fetch port (read only)
  input  logic                 ula_req,
  input  logic [AddrWidth-1:0] ula_addr,
  output logic                 ula_ack,
  output logic [DataWidth-1:0] ula_data,
  // CPU port
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AddrWidth-1:0] cpu_addr,
  input  logic [DataWidth-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DataWidth-1:0] cpu_rdata,
  // Physical VRAM port
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [DataWidth-1:0] mem_dout,
  // CPU waiting or in flight
  output logic                 cpu_pending
);

  // Reads spend READ_LAT-1 cycles in StWait; the counter runs down to zero.
  localparam logic [1:0] WaitInit = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  arb_state_e             state_q, state_d;
  arb_owner_e             owner_q;
  logic                   we_q;
  logic [1:0]             wait_q, wait_d;
  logic [AddrWidth-1:0]   mem_addr_q;
  logic [DataWidth-1:0]   mem_wdata_q;
  logic [DataWidth-1:0]   ula_data_q;
  logic [DataWidth-1:0]   cpu_rdata_q;
  logic                   pending_q, pending_d;

  logic                   idle;
  logic                   force_cpu;
  logic                   grant_ula;
  logic                   grant_cpu;
  logic                   cpu_rd_done;

  assign idle = (state_q == StIdle);

`ifdef VRAM_ARB_STARVE_EN
  vram_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_sys   (clk_sys),
    .nRESET    (nRESET),
    .ula_grant (grant_ula),
    .cpu_grant (grant_cpu),
    .cpu_req   (cpu_req),
    .force_cpu (force_cpu)
  );
`else
  assign force_cpu = 1'b0;
`endif

  // ULA wins unless the guard is forcing a waiting CPU in
  assign grant_ula = idle && ula_req && !(force_cpu && cpu_req);
  assign grant_cpu = idle && cpu_req && !grant_ula;

  // Next-state sequencing of a single access
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ula || grant_cpu) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q || (READ_LAT <= 1)) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          wait_d  = WaitInit;
        end
      end
      StWait: begin
        if (wait_q == 2'd0) begin
          state_d = StDone;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and wait counter registers
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Latch owner, address, write data and direction at grant time
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      owner_q     <= OwnUla;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant_ula) begin
      owner_q    <= OwnUla;
      we_q       <= 1'b0;
      mem_addr_q <= ula_addr;
    end else if (grant_cpu) begin
      owner_q     <= OwnCpu;
      we_q        <= cpu_we;
      mem_addr_q  <= cpu_addr;
      mem_wdata_q <= cpu_wdata;
    end
  end

  // Completion decode; data is passed through in the ack cycle, then held
  always_comb begin
    ula_ack     = (state_q == StDone) && (owner_q == OwnUla);
    cpu_ack     = (state_q == StDone) && (owner_q == OwnCpu);
    cpu_rd_done = cpu_ack && !we_q;
    ula_data    = ula_ack ? mem_dout : ula_data_q;
    cpu_rdata   = cpu_rd_done ? mem_dout : cpu_rdata_q;
    mem_we      = (state_q == StIssue) && (owner_q == OwnCpu) && we_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
  end

  // Hold last read data for each requester
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      ula_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (ula_ack) begin
        ula_data_q <= mem_dout;
      end
      if (cpu_rd_done) begin
        cpu_rdata_q <= mem_dout;
      end
    end
  end

  // Pending tracks a CPU request from first sighting in idle until its ack
  always_comb begin
    pending_d = pending_q;
    if (idle) begin
      pending_d = cpu_req;
    end else if (cpu_ack) begin
      pending_d = 1'b0;
    end
  end

  // Pending register
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign cpu_pending = pending_q | (idle & cpu_req);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: instance a uses READ_LAT=1, instance b
// READ_LAT=3; each has its own VRAM model preloaded with addr[7:0].
module tb_vram_arbiter;

  logic clk_sys = 1'b0;
  logic nRESET;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_sys = ~clk_sys;

  logic        a_ula_req, a_ula_ack, a_cpu_req, a_cpu_we, a_cpu_ack, a_mem_we, a_cpu_pending;
  logic [14:0] a_ula_addr, a_cpu_addr, a_mem_addr;
  logic [7:0]  a_ula_data, a_cpu_wdata, a_cpu_rdata, a_mem_wdata, a_mem_dout;
  logic        b_ula_req, b_ula_ack, b_cpu_req, b_cpu_we, b_cpu_ack, b_mem_we, b_cpu_pending;
  logic [14:0] b_ula_addr, b_cpu_addr, b_mem_addr;
  logic [7:0]  b_ula_data, b_cpu_wdata, b_cpu_rdata, b_mem_wdata, b_mem_dout;

  vram_arbiter #(.READ_LAT(1), .STARVE_LIMIT(4)) dut_a (
    .clk_sys(clk_sys), .nRESET(nRESET),
    .ula_req(a_ula_req), .ula_addr(a_ula_addr), .ula_ack(a_ula_ack), .ula_data(a_ula_data),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_dout(a_mem_dout),
    .cpu_pending(a_cpu_pending)
  );

  vram_arbiter #(.READ_LAT(3), .STARVE_LIMIT(4)) dut_b (
    .clk_sys(clk_sys), .nRESET(nRESET),
    .ula_req(b_ula_req), .ula_addr(b_ula_addr), .ula_ack(b_ula_ack), .ula_data(b_ula_data),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_dout(b_mem_dout),
    .cpu_pending(b_cpu_pending)
  );

  // VRAM models: synchronous write, read data valid READ_LAT cycles after issue
  logic [7:0] mem_a [0:32767];
  logic [7:0] mem_b [0:32767];
  logic [7:0] a_pipe;
  logic [7:0] b_pipe [0:2];

  always @(posedge clk_sys) begin
    if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_pipe <= mem_a[a_mem_addr];
  end
  assign a_mem_dout = a_pipe;

  always @(posedge clk_sys) begin
    if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_pipe[0] <= mem_b[b_mem_addr];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_dout = b_pipe[2];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Raise a ULA read on instance a; lat is cycles from request to ack (-1: none)
  task automatic a_ula_read(input logic [14:0] addr, output int lat, output logic [7:0] data);
    a_ula_req  = 1'b1;
    a_ula_addr = addr;
    lat  = -1;
    data = 8'hxx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if (a_ula_ack) begin
        lat  = k;
        data = a_ula_data;
        step();
        break;
      end
      step();
    end
    a_ula_req = 1'b0;
  endtask

  task automatic a_cpu_access(input logic we, input logic [14:0] addr, input logic [7:0] wdata,
                              output int lat, output logic [7:0] data);
    a_cpu_req   = 1'b1;
    a_cpu_we    = we;
    a_cpu_addr  = addr;
    a_cpu_wdata = wdata;
    lat  = -1;
    data = 8'hxx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if (a_cpu_ack) begin
        lat  = k;
        data = a_cpu_rdata;
        step();
        break;
      end
      step();
    end
    a_cpu_req = 1'b0;
    a_cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    logic [42:0] va, vb;
    step();
    va = {a_ula_ack, a_cpu_ack, a_mem_we, a_cpu_pending, a_mem_addr, a_mem_wdata,
          a_ula_data, a_cpu_rdata};
    vb = {b_ula_ack, b_cpu_ack, b_mem_we, b_cpu_pending, b_mem_addr, b_mem_wdata,
          b_ula_data, b_cpu_rdata};
    total++;
    if (va !== 43'd0) begin bad++; $display("FAIL reset_outputs_a: got %h want 0", va); end
    total++;
    if (vb !== 43'd0) begin bad++; $display("FAIL reset_outputs_b: got %h want 0", vb); end
    nRESET = 1'b1;
    step();
    step();
    @(negedge clk_sys);
    total++;
    if ({a_ula_ack, a_cpu_ack, a_mem_we, a_cpu_pending} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 0000",
               {a_ula_ack, a_cpu_ack, a_mem_we, a_cpu_pending});
    end
    step();
  endtask

  task automatic test_single_reads();
    int lat;
    logic [7:0] d;
    a_ula_read(15'h1800, lat, d);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL ula_read_lat: got %0d want 2", lat); end
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ula_read_data: got %h want 00", d); end
    a_cpu_access(1'b0, 15'h1A5A, 8'h00, lat, d);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL cpu_read_lat: got %0d want 2", lat); end
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL cpu_read_data: got %h want 5a", d); end
    step();
    total++;
    if (a_cpu_rdata !== 8'h5A) begin
      bad++; $display("FAIL cpu_rdata_hold: got %h want 5a", a_cpu_rdata);
    end
    total++;
    if (a_ula_data !== 8'h00) begin
      bad++; $display("FAIL ula_data_hold: got %h want 00", a_ula_data);
    end
  endtask

  task automatic test_collision();
    int ula_k = -1, cpu_k = -1, we_cnt = 0, we_k = -1, lat;
    logic [7:0] d;
    a_ula_req   = 1'b1;
    a_ula_addr  = 15'h0333;
    a_cpu_req   = 1'b1;
    a_cpu_we    = 1'b1;
    a_cpu_addr  = 15'h0100;
    a_cpu_wdata = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      if (a_ula_ack && ula_k < 0) begin
        ula_k = k;
        total++;
        if (a_ula_data !== 8'h33) begin
          bad++; $display("FAIL coll_ula_data: got %h want 33", a_ula_data);
        end
      end
      if (a_cpu_ack && cpu_k < 0) cpu_k = k;
      if (a_mem_we) begin
        we_cnt++;
        we_k = k;
        total++;
        if ({a_mem_addr, a_mem_wdata} !== {15'h0100, 8'h3C}) begin
          bad++;
          $display("FAIL coll_we_bus: got %h/%h want 0100/3c", a_mem_addr, a_mem_wdata);
        end
      end
      if (cpu_k >= 0 && k == cpu_k + 1) begin
        total++;
        if (a_cpu_pending !== 1'b0) begin
          bad++; $display("FAIL coll_pending_clear k=%0d: got %b want 0", k, a_cpu_pending);
        end
      end else if (cpu_k < 0 || k == cpu_k) begin
        total++;
        if (a_cpu_pending !== 1'b1) begin
          bad++; $display("FAIL coll_pending k=%0d: got %b want 1", k, a_cpu_pending);
        end
      end
      step();
      if (k == ula_k) a_ula_req = 1'b0;
      if (k == cpu_k) begin a_cpu_req = 1'b0; a_cpu_we = 1'b0; end
    end
    total++;
    if (ula_k !== 2) begin bad++; $display("FAIL coll_ula_ack: got %0d want 2", ula_k); end
    total++;
    if (cpu_k !== 5) begin bad++; $display("FAIL coll_cpu_ack: got %0d want 5", cpu_k); end
    total++;
    if (we_cnt !== 1) begin bad++; $display("FAIL coll_we_count: got %0d want 1", we_cnt); end
    total++;
    if (we_k !== ula_k + 2) begin
      bad++; $display("FAIL coll_we_cycle: got %0d want %0d", we_k, ula_k + 2);
    end
    a_cpu_access(1'b0, 15'h0100, 8'h00, lat, d);
    total++;
    if (d !== 8'h3C) begin bad++; $display("FAIL coll_readback: got %h want 3c", d); end
  endtask

  task automatic test_latency();
    int ack_k = -1, we_seen = 0;
    logic [7:0] d = 8'h00;
    b_cpu_req  = 1'b1;
    b_cpu_we   = 1'b0;
    b_cpu_addr = 15'h0042;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      if (b_mem_we) we_seen++;
      if (b_cpu_ack && ack_k < 0) begin ack_k = k; d = b_cpu_rdata; end
      step();
      if (k == ack_k) b_cpu_req = 1'b0;
    end
    total++;
    if (ack_k !== 4) begin bad++; $display("FAIL lat3_ack: got %0d want 4", ack_k); end
    total++;
    if (d !== 8'h42) begin bad++; $display("FAIL lat3_data: got %h want 42", d); end
    total++;
    if (we_seen !== 0) begin bad++; $display("FAIL lat3_we: got %0d want 0", we_seen); end
  endtask

  task automatic test_starvation();
    int cpu_k = -1, cpu_acks = 0, ula_before = 0, ula_after_k = -1, drained = 0;
    logic drop_u = 1'b0, drop_c = 1'b0;
    logic [7:0] cd = 8'h00;
    a_ula_req  = 1'b1;
    a_ula_addr = 15'h0010;
    a_cpu_req  = 1'b1;
    a_cpu_we   = 1'b0;
    a_cpu_addr = 15'h0077;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_sys);
      if (a_cpu_ack) begin
        cpu_acks++;
        if (cpu_k < 0) begin cpu_k = k; cd = a_cpu_rdata; end
      end
      if (a_ula_ack) begin
        if (cpu_k < 0) ula_before++;
        else if (ula_after_k < 0) ula_after_k = k;
      end
      step();
      if (k == cpu_k) a_cpu_req = 1'b0;
    end
`ifdef VRAM_ARB_STARVE_EN
    total++;
    if (cpu_k !== 14) begin bad++; $display("FAIL starve_cpu_ack: got %0d want 14", cpu_k); end
    total++;
    if (ula_before !== 4) begin
      bad++; $display("FAIL starve_ula_before: got %0d want 4", ula_before);
    end
    total++;
    if (ula_after_k !== 17) begin
      bad++; $display("FAIL starve_ula_resume: got %0d want 17", ula_after_k);
    end
    total++;
    if (cd !== 8'h77) begin bad++; $display("FAIL starve_cpu_data: got %h want 77", cd); end
    total++;
    if (cpu_acks !== 1) begin bad++; $display("FAIL starve_cpu_acks: got %0d want 1", cpu_acks); end
`else
    total++;
    if (cpu_acks !== 0) begin bad++; $display("FAIL nostarve_cpu_acks: got %0d want 0", cpu_acks); end
    total++;
    if (ula_before !== 66) begin
      bad++; $display("FAIL nostarve_ula_acks: got %0d want 66", ula_before);
    end
`endif
    // Release the ULA after its next ack and let any waiting CPU finish
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_sys);
      if (a_ula_ack) drop_u = 1'b1;
      if (a_cpu_ack) begin drained++; drop_c = 1'b1; end
      step();
      if (drop_u) a_ula_req = 1'b0;
      if (drop_c) a_cpu_req = 1'b0;
    end
`ifdef VRAM_ARB_STARVE_EN
    total++;
    if (drained !== 0) begin bad++; $display("FAIL starve_drain: got %0d want 0", drained); end
`else
    total++;
    if (drained !== 1) begin bad++; $display("FAIL nostarve_drain: got %0d want 1", drained); end
`endif
  endtask

  task automatic test_reset_mid();
    int acks = 0, ack_k = -1, lat;
    logic [7:0] d = 8'h00;
    b_cpu_req  = 1'b1;
    b_cpu_we   = 1'b0;
    b_cpu_addr = 15'h1234;
    step();
    step();
    // Instance b is now in its first wait cycle
    nRESET    = 1'b0;
    b_cpu_req = 1'b0;
    #1;
    total++;
    if ({b_ula_ack, b_cpu_ack, b_mem_we, b_cpu_pending, b_mem_addr, b_mem_wdata,
         b_ula_data, b_cpu_rdata} !== 43'd0) begin
      bad++;
      $display("FAIL midreset_b: addr=%h rdata=%h pend=%b want all 0",
               b_mem_addr, b_cpu_rdata, b_cpu_pending);
    end
    total++;
    if (a_cpu_rdata !== 8'h00) begin
      bad++; $display("FAIL midreset_a_rdata: got %h want 00", a_cpu_rdata);
    end
    step();
    step();
    nRESET = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      if (b_cpu_ack || b_ula_ack) acks++;
      step();
    end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL midreset_noack: got %0d want 0", acks); end
    b_ula_req  = 1'b1;
    b_ula_addr = 15'h2233;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      if (b_ula_ack && ack_k < 0) begin ack_k = k; d = b_ula_data; end
      step();
      if (k == ack_k) b_ula_req = 1'b0;
    end
    total++;
    if (ack_k !== 4) begin bad++; $display("FAIL postreset_b_lat: got %0d want 4", ack_k); end
    total++;
    if (d !== 8'h33) begin bad++; $display("FAIL postreset_b_data: got %h want 33", d); end
    a_ula_read(15'h0155, lat, d);
    total++;
    if (lat !== 2 || d !== 8'h55) begin
      bad++; $display("FAIL postreset_a_read: got lat=%0d data=%h want 2/55", lat, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] wa [3] = '{15'h0200, 15'h0201, 15'h0202};
    logic [7:0]  wd [3] = '{8'hA1, 8'hA2, 8'hA3};
    int ack_k [3] = '{-1, -1, -1};
    int we_k  [3] = '{-1, -1, -1};
    int nacks = 0, nwe = 0, idx = 0, lat;
    logic ack_now;
    logic [7:0] d;
    a_cpu_req   = 1'b1;
    a_cpu_we    = 1'b1;
    a_cpu_addr  = wa[0];
    a_cpu_wdata = wd[0];
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_sys);
      ack_now = a_cpu_ack;
      if (a_mem_we) begin
        if (nwe < 3) we_k[nwe] = k;
        nwe++;
      end
      if (a_cpu_ack) begin
        if (nacks < 3) ack_k[nacks] = k;
        nacks++;
      end
      step();
      if (ack_now) begin
        idx++;
        if (idx < 3) begin
          a_cpu_addr  = wa[idx];
          a_cpu_wdata = wd[idx];
        end else begin
          a_cpu_req = 1'b0;
          a_cpu_we  = 1'b0;
        end
      end
    end
    total++;
    if (nacks !== 3) begin bad++; $display("FAIL b2b_acks: got %0d want 3", nacks); end
    total++;
    if (nwe !== 3) begin bad++; $display("FAIL b2b_we_pulses: got %0d want 3", nwe); end
    total++;
    if (ack_k[0] !== 2) begin bad++; $display("FAIL b2b_first_ack: got %0d want 2", ack_k[0]); end
    total++;
    if (ack_k[1] - ack_k[0] !== 3 || ack_k[2] - ack_k[1] !== 3) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d,%0d,%0d want 2,5,8", ack_k[0], ack_k[1], ack_k[2]);
    end
    total++;
    if (we_k[0] !== 1 || we_k[2] - we_k[0] !== 6) begin
      bad++; $display("FAIL b2b_we_cycles: got %0d,%0d,%0d want 1,4,7", we_k[0], we_k[1], we_k[2]);
    end
    a_cpu_access(1'b0, 15'h0201, 8'h00, lat, d);
    total++;
    if (d !== 8'hA2) begin bad++; $display("FAIL b2b_readback1: got %h want a2", d); end
    a_cpu_access(1'b0, 15'h0202, 8'h00, lat, d);
    total++;
    if (d !== 8'hA3) begin bad++; $display("FAIL b2b_readback2: got %h want a3", d); end
  endtask

  initial begin
    nRESET = 1'b0;
    {a_ula_req, a_cpu_req, a_cpu_we, b_ula_req, b_cpu_req, b_cpu_we} = '0;
    {a_ula_addr, a_cpu_addr, b_ula_addr, b_cpu_addr} = '0;
    {a_cpu_wdata, b_cpu_wdata} = '0;
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = i[7:0];
      mem_b[i] = i[7:0];
    end
    test_reset();
    test_single_reads();
    test_collision();
    test_latency();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
